alu_div_seq: RTL and testbench

Multi-cycle 32-bit divider controller that borrows the shared datapath ALU to implement DIV/DIVU without a dedicated subtractor. It runs restoring division as a sequence of ALU SLTU and SUB operations, drives the ALU operand and opcode inputs while it owns them, and returns quotient and remainder through a start/done handshake. It sits beside the ALU in the execute stage; the datapath muxes ALU inputs from this block whenever `alu_own` is high.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_div_seq_if.sv | 34 +++
 rtl/alu_div_seq.sv | 181 ++++++++++++++++++
 tb/tb_alu_div_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants used by the ALU decoder and by
// every block that borrows the ALU, plus the divider controller state set.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;
    localparam logic [4:0] ALU_LUI  = 5'b01010;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_NEG_A,
        DIV_NEG_B,
        DIV_CMP,
        DIV_SUB,
        DIV_FIX_Q,
        DIV_FIX_R,
        DIV_DONE
    } div_state_e;

endpackage

// File: rtl/alu_div_seq_if.sv
// Divider request/result handshake together with the borrowed ALU port.
// The master side issues divides; the slave side is the divider itself.
interface alu_div_seq_if;
    import alu_pkg::*;

    logic              start;
    logic              is_signed;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;

    logic              alu_own;
    logic [4:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_checkover;
    logic [DATA_W-1:0] alu_result;

    modport master (
        output start, is_signed, dividend, divisor, alu_result,
        input  busy, done, quotient, remainder,
               alu_own, alu_op, alu_a, alu_b, alu_checkover
    );

    modport slave (
        input  start, is_signed, dividend, divisor, alu_result,
        output busy, done, quotient, remainder,
               alu_own, alu_op, alu_a, alu_b, alu_checkover
    );

endinterface

// File: rtl/alu_div_seq.sv
// Restoring 32-bit DIV/DIVU controller that borrows the shared ALU for every
// compare and subtract; results stay in the working registers until the next start.
module alu_div_seq
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    alu_div_seq_if.slave bus
);

    div_state_e  r_state;
    div_state_e  w_nextState;

    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [4:0]  r_cnt;
    logic        r_negA;
    logic        r_negB;
    logic        r_zeroWait;

    logic [31:0] w_remSh;
    logic        w_carry;
    logic        w_ge;
    logic        w_lastIter;
    div_state_e  w_postLoop;

    logic        w_aluOwn;
    logic [4:0]  w_aluOp;
    logic [31:0] w_aluA;
    logic [31:0] w_aluB;
    logic        w_done;

    assign w_remSh    = {r_rem[30:0], r_dvd[31]};
    assign w_carry    = r_rem[31];
    assign w_ge       = w_carry || (bus.alu_result == 32'd0);
    assign w_lastIter = (r_cnt == 5'd31);

    // Sign correction order: quotient first, then remainder takes the dividend's sign.
    assign w_postLoop = (r_negA != r_negB) ? DIV_FIX_Q :
                        r_negA             ? DIV_FIX_R : DIV_DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DIV_IDLE;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_negA     <= 1'b0;
            r_negB     <= 1'b0;
            r_zeroWait <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                DIV_IDLE: begin
                    if (bus.start) begin
                        r_dvd      <= bus.dividend;
                        r_dvs      <= bus.divisor;
                        r_negA     <= bus.is_signed && bus.dividend[31];
                        r_negB     <= bus.is_signed && bus.divisor[31];
                        r_cnt      <= '0;
                        r_zeroWait <= (bus.divisor == 32'd0);
                        if (bus.divisor == 32'd0) begin
                            r_quo <= '1;
                            r_rem <= bus.dividend;
                        end else begin
                            r_quo <= '0;
                            r_rem <= '0;
                        end
                    end
                end
                DIV_NEG_A: r_dvd <= bus.alu_result;
                DIV_NEG_B: r_dvs <= bus.alu_result;
                DIV_CMP: begin
                    r_rem <= w_remSh;
                    r_dvd <= {r_dvd[30:0], 1'b0};
                    if (!w_ge) begin
                        r_quo <= {r_quo[30:0], 1'b0};
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                DIV_SUB: begin
                    // With carry set the true remainder is 33 bits; the 32-bit wrap is exact.
                    r_rem <= bus.alu_result;
                    r_quo <= {r_quo[30:0], 1'b1};
                    r_cnt <= r_cnt + 5'd1;
                end
                DIV_FIX_Q: r_quo <= bus.alu_result;
                DIV_FIX_R: r_rem <= bus.alu_result;
                DIV_DONE:  r_zeroWait <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_aluOwn    = 1'b0;
        w_aluOp     = ALU_ADD;
        w_aluA      = '0;
        w_aluB      = '0;
        w_done      = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == 32'd0)
                        w_nextState = DIV_DONE;
                    else if (bus.is_signed && bus.dividend[31])
                        w_nextState = DIV_NEG_A;
                    else if (bus.is_signed && bus.divisor[31])
                        w_nextState = DIV_NEG_B;
                    else
                        w_nextState = DIV_CMP;
                end
            end
            DIV_NEG_A: begin
                w_aluOwn    = 1'b1;
                w_aluOp     = ALU_SUB;
                w_aluB      = r_dvd;
                w_nextState = r_negB ? DIV_NEG_B : DIV_CMP;
            end
            DIV_NEG_B: begin
                w_aluOwn    = 1'b1;
                w_aluOp     = ALU_SUB;
                w_aluB      = r_dvs;
                w_nextState = DIV_CMP;
            end
            DIV_CMP: begin
                w_aluOwn = 1'b1;
                w_aluOp  = ALU_SLTU;
                w_aluA   = w_remSh;
                w_aluB   = r_dvs;
                if (w_ge)
                    w_nextState = DIV_SUB;
                else if (w_lastIter)
                    w_nextState = w_postLoop;
                else
                    w_nextState = DIV_CMP;
            end
            DIV_SUB: begin
                w_aluOwn    = 1'b1;
                w_aluOp     = ALU_SUB;
                w_aluA      = r_rem;
                w_aluB      = r_dvs;
                w_nextState = w_lastIter ? w_postLoop : DIV_CMP;
            end
            DIV_FIX_Q: begin
                w_aluOwn    = 1'b1;
                w_aluOp     = ALU_SUB;
                w_aluB      = r_quo;
                w_nextState = r_negA ? DIV_FIX_R : DIV_DONE;
            end
            DIV_FIX_R: begin
                w_aluOwn    = 1'b1;
                w_aluOp     = ALU_SUB;
                w_aluB      = r_rem;
                w_nextState = DIV_DONE;
            end
            DIV_DONE: begin
                // Divide-by-zero settles one cycle here so its result also lands one edge after start.
                w_done      = !r_zeroWait;
                w_nextState = r_zeroWait ? DIV_DONE : DIV_IDLE;
            end
            default: w_nextState = DIV_IDLE;
        endcase
    end

    assign bus.busy          = (r_state != DIV_IDLE) && !w_done;
    assign bus.done          = w_done;
    assign bus.quotient      = r_quo;
    assign bus.remainder     = r_rem;
    assign bus.alu_own       = w_aluOwn;
    assign bus.alu_op        = w_aluOp;
    assign bus.alu_a         = w_aluA;
    assign bus.alu_b         = w_aluB;
    assign bus.alu_checkover = 1'b0;

endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: models the shared ALU, runs a table of directed
// divides plus random ones against an arithmetic reference, and corner sequences.
module tb_alu_div_seq;
    import alu_pkg::*;

    logic clk;
    logic rst;

    alu_div_seq_if bus();

    alu_div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared execute-stage ALU as seen by the divider.
    always_comb begin
        case (bus.alu_op)
            ALU_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
            ALU_SLTU: bus.alu_result = {31'd0, (bus.alu_a < bus.alu_b)};
            default:  bus.alu_result = bus.alu_a + bus.alu_b;
        endcase
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        int          sltu;
        int          subs;
    } vec_t;

    int total = 0;
    int bad   = 0;
    localparam int LIMIT = 120;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output int lat, output int sltu, output int subs);
        longint sa, sb, sq, sr, mq;
        int p, f, s;
        if (b == 32'd0) begin
            q = '1; r = a; lat = 1; sltu = 0; subs = 0;
            return;
        end
        if (!sgn) begin
            sa = longint'(a); sb = longint'(b);
            p = 0; f = 0;
        end else begin
            sa = $signed(a); sb = $signed(b);
            p = int'(sa < 0) + int'(sb < 0);
            f = int'((sa < 0) != (sb < 0)) + int'(sa < 0);
        end
        sq = sa / sb;
        sr = sa - sq * sb;
        mq = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
        q = sq[31:0];
        r = sr[31:0];
        s = $countones(mq[31:0]);
        lat  = p + 32 + s + f;
        sltu = 32;
        subs = p + s + f;
    endfunction

    task automatic startOp(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Starts a divide and follows it to done, tallying ALU usage per cycle.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 input int injectAt,
                                 output int edges, output int sltu, output int subs,
                                 output int badIdle, output int badCo);
        startOp(sgn, a, b);
        edges = 0; sltu = 0; subs = 0; badIdle = 0; badCo = 0;
        forever begin
            if (bus.alu_own) begin
                if (bus.alu_op == ALU_SLTU) sltu++;
                if (bus.alu_op == ALU_SUB)  subs++;
            end else if (bus.alu_op != ALU_ADD || bus.alu_a != 0 || bus.alu_b != 0) begin
                badIdle++;
            end
            if (bus.alu_checkover) badCo++;
            if (bus.done || edges >= LIMIT) break;
            if (edges == injectAt) begin
                bus.start = 1'b1; bus.is_signed = 1'b0;
                bus.dividend = 32'd9; bus.divisor = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        bus.start = 1'b0;
    endtask

    task automatic runVec(input string tag, input vec_t v, input int injectAt);
        int edges, sltu, subs, badIdle, badCo;
        applyStimulus(v.sgn, v.a, v.b, injectAt, edges, sltu, subs, badIdle, badCo);
        checkOutput({tag, " done seen"}, 32'(bus.done), 32'd1);
        checkOutput({tag, " quotient"}, bus.quotient, v.q);
        checkOutput({tag, " remainder"}, bus.remainder, v.r);
        checkOutput({tag, " latency"}, 32'(edges), 32'(v.lat));
        checkOutput({tag, " sltu count"}, 32'(sltu), 32'(v.sltu));
        checkOutput({tag, " sub count"}, 32'(subs), 32'(v.subs));
        checkOutput({tag, " idle drive"}, 32'(badIdle), 32'd0);
        checkOutput({tag, " checkover"}, 32'(badCo), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, " done pulse"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " busy after"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " quotient held"}, bus.quotient, v.q);
        checkOutput({tag, " remainder held"}, bus.remainder, v.r);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " alu_own"}, 32'(bus.alu_own), 32'd0);
        checkOutput({tag, " alu_op"}, 32'(bus.alu_op), 32'(ALU_ADD));
        checkOutput({tag, " alu_a"}, bus.alu_a, 32'd0);
        checkOutput({tag, " alu_b"}, bus.alu_b, 32'd0);
        checkOutput({tag, " checkover"}, 32'(bus.alu_checkover), 32'd0);
        checkOutput({tag, " quotient"}, bus.quotient, 32'd0);
        checkOutput({tag, " remainder"}, bus.remainder, 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        vec_t v;
        int   busyBad;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        35, 32, 3};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 37, 32, 5};
        vecs[2] = '{1'b0, 32'hFFFFFFFF,   32'h80000000, 32'd1,        32'h7FFFFFFF, 33, 32, 1};
        vecs[3] = '{1'b1, 32'h80000005,   32'd0,        32'hFFFFFFFF, 32'h80000005, 1,  0,  0};
        vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        36, 32, 4};
        vecs[5] = '{1'b0, 32'd9,          32'd3,        32'd3,        32'd0,        34, 32, 2};
        vecs[6] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        36, 32, 4};
        vecs[7] = '{1'b0, 32'd0,          32'd5,        32'd0,        32'd0,        32, 32, 0};
        vecs[8] = '{1'b0, 32'd0,          32'd0,        32'hFFFFFFFF, 32'd0,        1,  0,  0};

        bus.start = 1'b0; bus.is_signed = 1'b0;
        bus.dividend = '0; bus.divisor = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            runVec($sformatf("vec%0d", i), vecs[i], -1);

        for (int i = 0; i < 40; i++) begin
            v.sgn = 1'($urandom_range(0, 1));
            v.a   = $urandom;
            case ($urandom_range(0, 5))
                0:       v.b = 32'd0;
                1:       v.b = $urandom | 32'h80000000;
                2:       v.b = 32'hFFFFFFFF;
                default: v.b = $urandom >> $urandom_range(0, 31);
            endcase
            refDiv(v.sgn, v.a, v.b, v.q, v.r, v.lat, v.sltu, v.subs);
            runVec($sformatf("rand%0d", i), v, -1);
        end

        // A start arriving mid-divide must neither disturb the result nor be queued.
        runVec("ignored start", vecs[0], 10);
        busyBad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.busy || bus.alu_own) busyBad++;
        end
        checkOutput("no queued start", 32'(busyBad), 32'd0);

        // Reset in the middle of a divide drops everything on the next edge.
        startOp(1'b0, 32'd100, 32'd7);
        for (int c = 1; c < 20; c++) begin
            bus.start = (c == 10);
            if (c == 10) begin
                bus.dividend = 32'd9; bus.divisor = 32'd3;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        checkOutput("busy before reset", 32'(bus.busy), 32'd1);
        checkOutput("alu_own before reset", 32'(bus.alu_own), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetValues("mid reset");
        rst = 1'b0;
        runVec("after reset", vecs[5], -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
